// File: rtl/bp_cce_mem_cmd_router.sv
// Address-window router between the CCE memory port, DRAM and the loopback tie-off.
// Optional misroute counter: define BP_CCE_MEM_ROUTER_ERR_CNT_EN.

package bp_cce_mem_router_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0,
        e_bp_wide_cfg    = 1'b1
    } bp_params_e;

    // Message layout, MSB to LSB: {data, size[2:0], msg_type[3:0], addr}
    localparam int unsigned msg_ctl_width_gp = 7;

    function automatic int unsigned paddr_width(input bp_params_e cfg);
        return (cfg == e_bp_wide_cfg) ? 48 : 40;
    endfunction

    function automatic int unsigned data_width(input bp_params_e cfg);
        return (cfg == e_bp_wide_cfg) ? 512 : 64;
    endfunction

    function automatic int unsigned msg_width(input bp_params_e cfg);
        return data_width(cfg) + msg_ctl_width_gp + paddr_width(cfg);
    endfunction

endpackage

module bp_cce_mem_cmd_router
    import bp_cce_mem_router_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
    localparam int unsigned paddr_width_p = paddr_width(bp_params_p),
    localparam int unsigned cce_mem_msg_width_lp = msg_width(bp_params_p),
    parameter logic [paddr_width_p-1:0] dram_base_p = paddr_width_p'(64'h8000_0000),
    parameter logic [paddr_width_p-1:0] dram_bound_p = paddr_width_p'(64'h10_0000_0000),
    parameter int unsigned max_outstanding_p = 8,
    parameter int unsigned err_cnt_width_p = 16
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,

    input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
    input  logic                            mem_cmd_v_i,
    output logic                            mem_cmd_ready_o,

    output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
    output logic                            mem_resp_v_o,
    input  logic                            mem_resp_yumi_i,

    output logic [cce_mem_msg_width_lp-1:0] dram_cmd_o,
    output logic                            dram_cmd_v_o,
    input  logic                            dram_cmd_ready_i,
    input  logic [cce_mem_msg_width_lp-1:0] dram_resp_i,
    input  logic                            dram_resp_v_i,
    output logic                            dram_resp_yumi_o,

    output logic [cce_mem_msg_width_lp-1:0] lb_cmd_o,
    output logic                            lb_cmd_v_o,
    input  logic                            lb_cmd_ready_i,
    input  logic [cce_mem_msg_width_lp-1:0] lb_resp_i,
    input  logic                            lb_resp_v_i,
    output logic                            lb_resp_yumi_o,

    output logic [err_cnt_width_p-1:0]      err_count_o
);

    localparam int unsigned ptr_w_lp = $clog2(max_outstanding_p);
    localparam logic [ptr_w_lp:0] depth_lp = (ptr_w_lp + 1)'(max_outstanding_p);

    logic [paddr_width_p-1:0] addr;
    logic                     in_win;
    logic                     run;
    logic                     full;
    logic                     empty;
    logic                     head_dram;
    logic                     push;
    logic                     pop;

    logic                     tag_q [max_outstanding_p];
    logic [ptr_w_lp-1:0]      wr_ptr_q;
    logic [ptr_w_lp-1:0]      wr_ptr_d;
    logic [ptr_w_lp-1:0]      rd_ptr_q;
    logic [ptr_w_lp-1:0]      rd_ptr_d;
    logic [ptr_w_lp:0]        cnt_q;
    logic [ptr_w_lp:0]        cnt_d;

    assign addr   = mem_cmd_i[paddr_width_p-1:0];
    assign in_win = (addr >= dram_base_p) && (addr < dram_bound_p);

    // Reset gates every handshake output combinationally, not just via state.
    assign run   = reset_n_i;
    assign full  = (cnt_q == depth_lp);
    assign empty = (cnt_q == '0);

    assign dram_cmd_o   = mem_cmd_i;
    assign lb_cmd_o     = mem_cmd_i;
    assign dram_cmd_v_o = run & mem_cmd_v_i & in_win & ~full;
    assign lb_cmd_v_o   = run & mem_cmd_v_i & ~in_win & ~full;

    assign mem_cmd_ready_o = run & ~full
                           & (in_win ? dram_cmd_ready_i : lb_cmd_ready_i);

    assign head_dram    = tag_q[rd_ptr_q];
    assign mem_resp_o   = head_dram ? dram_resp_i : lb_resp_i;
    assign mem_resp_v_o = run & ~empty
                        & (head_dram ? dram_resp_v_i : lb_resp_v_i);

    assign push = mem_cmd_v_i & mem_cmd_ready_o;
    assign pop  = run & ~empty & mem_resp_yumi_i;

    assign dram_resp_yumi_o = pop & head_dram;
    assign lb_resp_yumi_o   = pop & ~head_dram;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Tag payload needs no reset: the pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_q[wr_ptr_q] <= in_win;
        end
    end

`ifdef BP_CCE_MEM_ROUTER_ERR_CNT_EN
    logic [err_cnt_width_p-1:0] err_q;
    logic [err_cnt_width_p-1:0] err_d;

    always_comb begin
        err_d = err_q;
        if (push && !in_win && (err_q != '1)) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count_o = err_q;
`else
    assign err_count_o = '0;
`endif

endmodule

// File: tb/tb_bp_cce_mem_cmd_router.sv
// Randomized bench for bp_cce_mem_cmd_router against a queue-based reference model.
// Honours BP_CCE_MEM_ROUTER_ERR_CNT_EN for the expected misroute count.

module tb_bp_cce_mem_cmd_router;
    import bp_cce_mem_router_pkg::*;

    localparam int PW    = paddr_width(e_bp_default_cfg);
    localparam int DW    = data_width(e_bp_default_cfg);
    localparam int MW    = msg_width(e_bp_default_cfg);
    localparam int DEPTH = 8;
    localparam int EW    = 16;
    localparam longint unsigned BASE  = 64'h8000_0000;
    localparam longint unsigned BOUND = 64'h10_0000_0000;
    localparam int STALL = 1000000000;

    logic          clk = 1'b0;
    logic          reset_n_i;
    logic [MW-1:0] mem_cmd_i;
    logic          mem_cmd_v_i;
    logic          mem_cmd_ready_o;
    logic [MW-1:0] mem_resp_o;
    logic          mem_resp_v_o;
    logic          mem_resp_yumi_i;
    logic [MW-1:0] dram_cmd_o;
    logic          dram_cmd_v_o;
    logic          dram_cmd_ready_i;
    logic [MW-1:0] dram_resp_i;
    logic          dram_resp_v_i;
    logic          dram_resp_yumi_o;
    logic [MW-1:0] lb_cmd_o;
    logic          lb_cmd_v_o;
    logic          lb_cmd_ready_i;
    logic [MW-1:0] lb_resp_i;
    logic          lb_resp_v_i;
    logic          lb_resp_yumi_o;
    logic [EW-1:0] err_count_o;

    bp_cce_mem_cmd_router #(
        .bp_params_p      (e_bp_default_cfg),
        .max_outstanding_p(DEPTH),
        .err_cnt_width_p  (EW)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n_i),
        .mem_cmd_i       (mem_cmd_i),
        .mem_cmd_v_i     (mem_cmd_v_i),
        .mem_cmd_ready_o (mem_cmd_ready_o),
        .mem_resp_o      (mem_resp_o),
        .mem_resp_v_o    (mem_resp_v_o),
        .mem_resp_yumi_i (mem_resp_yumi_i),
        .dram_cmd_o      (dram_cmd_o),
        .dram_cmd_v_o    (dram_cmd_v_o),
        .dram_cmd_ready_i(dram_cmd_ready_i),
        .dram_resp_i     (dram_resp_i),
        .dram_resp_v_i   (dram_resp_v_i),
        .dram_resp_yumi_o(dram_resp_yumi_o),
        .lb_cmd_o        (lb_cmd_o),
        .lb_cmd_v_o      (lb_cmd_v_o),
        .lb_cmd_ready_i  (lb_cmd_ready_i),
        .lb_resp_i       (lb_resp_i),
        .lb_resp_v_i     (lb_resp_v_i),
        .lb_resp_yumi_o  (lb_resp_yumi_o),
        .err_count_o     (err_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MW-1:0] resp;
        int            ready_at;
    } pend_t;

    pend_t         dq[$];
    pend_t         lq[$];
    bit            tags[$];
    logic [MW-1:0] ordq[$];

    int            n_chk = 0;
    int            n_pass = 0;
    int            cyc = 0;
    int            errm = 0;
    int            dram_dly_max = 8;
    bit            dram_stall = 0;
    bit            win_only = 0;
    bit            cur_v = 0;
    logic [MW-1:0] cur_cmd = '0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      tag, got, exp, cyc);
    endtask

    function automatic logic [PW-1:0] pick_addr(input bit in_only);
        longint unsigned r;
        longint unsigned a;
        int k;
        r = {$urandom, $urandom};
        k = in_only ? $urandom_range(0, 3) : $urandom_range(0, 9);
        case (k)
            0:       a = BASE;
            1:       a = BOUND - 1;
            2, 3:    a = BASE + (r % (BOUND - BASE));
            4:       a = BASE - 1;
            5:       a = BOUND;
            6:       a = 0;
            7:       a = (64'd1 << PW) - 1;
            default: a = r % (64'd1 << PW);
        endcase
        return a[PW-1:0];
    endfunction

    function automatic logic [MW-1:0] mk_cmd(input logic [PW-1:0] a);
        logic [DW-1:0] d;
        logic [6:0]    ctl;
        d   = {$urandom, $urandom};
        ctl = 7'($urandom);
        return {d, ctl, a};
    endfunction

    function automatic bit in_window(input logic [MW-1:0] c);
        longint unsigned a;
        a = 64'(c[PW-1:0]);
        return (a >= BASE) && (a < BOUND);
    endfunction

    function automatic logic [MW-1:0] dram_reply(input logic [MW-1:0] c);
        logic [DW-1:0] d;
        d = c[MW-1:MW-DW] ^ 64'hA5A5_5A5A_0F0F_F0F0;
        return {d, c[MW-DW-1:0]};
    endfunction

    function automatic logic [MW-1:0] lb_reply(input logic [MW-1:0] c);
        logic [DW-1:0] z;
        z = '0;
        return {z, c[MW-DW-1:0]};
    endfunction

    task automatic step();
        bit full, empty, inw, head, dv, lv;
        bit e_dv, e_lv, e_rdy, e_rv, y;
        int dly;
        @(posedge clk);
        #1;
        cyc++;
        if (!cur_v && ($urandom_range(0, 3) != 0)) begin
            cur_cmd = mk_cmd(pick_addr(win_only));
            cur_v   = 1'b1;
        end
        mem_cmd_i        = cur_cmd;
        mem_cmd_v_i      = cur_v;
        dram_cmd_ready_i = ($urandom_range(0, 3) != 0);
        lb_cmd_ready_i   = ($urandom_range(0, 3) != 0);
        dv = (dq.size() > 0) && (dq[0].ready_at <= cyc);
        lv = (lq.size() > 0) && (lq[0].ready_at <= cyc);
        dram_resp_v_i = dv;
        lb_resp_v_i   = lv;
        dram_resp_i   = (dq.size() > 0) ? dq[0].resp : '0;
        lb_resp_i     = (lq.size() > 0) ? lq[0].resp : '0;

        full  = (tags.size() == DEPTH);
        empty = (tags.size() == 0);
        inw   = in_window(cur_cmd);
        head  = !empty && tags[0];
        e_dv  = cur_v && inw && !full;
        e_lv  = cur_v && !inw && !full;
        e_rdy = !full && (inw ? dram_cmd_ready_i : lb_cmd_ready_i);
        e_rv  = !empty && (head ? dv : lv);
        if (e_rv) y = ($urandom_range(0, 2) != 0);
        else if (empty) y = $urandom_range(0, 1);
        else y = 1'b0;
        mem_resp_yumi_i = y;
        #1;

        chk("cmd_ready", mem_cmd_ready_o, e_rdy);
        chk("dram_cmd_v", dram_cmd_v_o, e_dv);
        chk("lb_cmd_v", lb_cmd_v_o, e_lv);
        if (e_dv) chk("dram_cmd", dram_cmd_o, cur_cmd);
        if (e_lv) chk("lb_cmd", lb_cmd_o, cur_cmd);
        chk("resp_v", mem_resp_v_o, e_rv);
        if (e_rv) chk("resp_order", mem_resp_o, ordq[0]);
        chk("dram_yumi", dram_resp_yumi_o, y && !empty && head);
        chk("lb_yumi", lb_resp_yumi_o, y && !empty && !head);
        chk("err_count", err_count_o, errm);

        if (cur_v && e_rdy) begin
            tags.push_back(inw);
            if (inw) begin
                dly = dram_stall ? STALL : $urandom_range(0, dram_dly_max);
                dq.push_back('{dram_reply(cur_cmd), cyc + 1 + dly});
                ordq.push_back(dram_reply(cur_cmd));
            end else begin
                dly = $urandom_range(0, 4);
                lq.push_back('{lb_reply(cur_cmd), cyc + 1 + dly});
                ordq.push_back(lb_reply(cur_cmd));
`ifdef BP_CCE_MEM_ROUTER_ERR_CNT_EN
                if (errm < (1 << EW) - 1) errm++;
`endif
            end
            cur_v = 1'b0;
        end
        if (y && !empty) begin
            void'(tags.pop_front());
            void'(ordq.pop_front());
            if (head) void'(dq.pop_front());
            else void'(lq.pop_front());
        end
    endtask

    task automatic check_quiet(input string pfx);
        chk({pfx, "_ready"}, mem_cmd_ready_o, 1'b0);
        chk({pfx, "_dram_v"}, dram_cmd_v_o, 1'b0);
        chk({pfx, "_lb_v"}, lb_cmd_v_o, 1'b0);
        chk({pfx, "_resp_v"}, mem_resp_v_o, 1'b0);
        chk({pfx, "_dram_yumi"}, dram_resp_yumi_o, 1'b0);
        chk({pfx, "_lb_yumi"}, lb_resp_yumi_o, 1'b0);
        chk({pfx, "_err"}, err_count_o, 0);
    endtask

    task automatic hit_reset(input string pfx);
        @(posedge clk);
        #1;
        mem_cmd_i        = mk_cmd(pick_addr(1'b0));
        mem_cmd_v_i      = 1'b1;
        dram_cmd_ready_i = 1'b1;
        lb_cmd_ready_i   = 1'b1;
        dram_resp_v_i    = 1'b1;
        lb_resp_v_i      = 1'b1;
        mem_resp_yumi_i  = 1'b1;
        #1;
        reset_n_i = 1'b0;
        #1;
        check_quiet(pfx);
        tags.delete();
        ordq.delete();
        dq.delete();
        lq.delete();
        errm  = 0;
        cur_v = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n_i   = 1'b1;
        mem_cmd_v_i = 1'b0;
        #1;
        chk({pfx, "_post_resp_v"}, mem_resp_v_o, 1'b0);
        chk({pfx, "_post_dram_yumi"}, dram_resp_yumi_o, 1'b0);
        chk({pfx, "_post_lb_yumi"}, lb_resp_yumi_o, 1'b0);
        chk({pfx, "_post_err"}, err_count_o, 0);
    endtask

    initial begin
        reset_n_i        = 1'b0;
        mem_cmd_i        = '0;
        mem_cmd_v_i      = 1'b1;
        mem_resp_yumi_i  = 1'b0;
        dram_cmd_ready_i = 1'b1;
        dram_resp_i      = '0;
        dram_resp_v_i    = 1'b1;
        lb_cmd_ready_i   = 1'b1;
        lb_resp_i        = '0;
        lb_resp_v_i      = 1'b1;
        #2;
        check_quiet("rst");
        repeat (2) @(posedge clk);
        #1;
        reset_n_i   = 1'b1;
        mem_cmd_v_i = 1'b0;

        repeat (1500) step();
        hit_reset("rst_mid1");

        dram_stall = 1'b1;
        win_only   = 1'b1;
        repeat (60) step();
        chk("stall_full", tags.size() == DEPTH, 1'b1);
        dram_stall = 1'b0;
        foreach (dq[i]) dq[i].ready_at = cyc;
        repeat (300) step();
        win_only = 1'b0;

        dram_dly_max = 30;
        repeat (1200) step();
        dram_dly_max = 8;
        hit_reset("rst_mid2");
        repeat (500) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
